// File: rtl/lcd_img_pkg.sv
// Shared definitions for the LCD image processor: controller states and command codes.
package lcd_img_pkg;

    typedef enum logic [2:0] {
        StLoad,
        StIdle,
        StOp,
        StWrite,
        StDone
    } state_e;

    localparam logic [3:0] CmdWrite  = 4'd0;
    localparam logic [3:0] CmdUp     = 4'd1;
    localparam logic [3:0] CmdDown   = 4'd2;
    localparam logic [3:0] CmdLeft   = 4'd3;
    localparam logic [3:0] CmdRight  = 4'd4;
    localparam logic [3:0] CmdMax    = 4'd5;
    localparam logic [3:0] CmdMin    = 4'd6;
    localparam logic [3:0] CmdAvg    = 4'd7;
    localparam logic [3:0] CmdRotCcw = 4'd8;
    localparam logic [3:0] CmdRotCw  = 4'd9;
    localparam logic [3:0] CmdMirX   = 4'd10;
    localparam logic [3:0] CmdMirY   = 4'd11;

endpackage

// File: rtl/lcd_quad_alu.sv
// Combinational 2x2 quad operator: a=(r-1,c-1), b=(r-1,c), c=(r,c-1), d=(r,c).
module lcd_quad_alu
    import lcd_img_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [3:0]    cmd_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [DW-1:0] c_o,
    output logic [DW-1:0] d_o
);

    logic [DW+1:0] sum;
    logic [DW-1:0] max_ab, max_cd, max_all;
    logic [DW-1:0] min_ab, min_cd, min_all;
    logic [DW-1:0] avg;

    always_comb begin
        sum     = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i} + {2'b00, d_i};
        avg     = sum[DW+1:2];
        max_ab  = (a_i > b_i) ? a_i : b_i;
        max_cd  = (c_i > d_i) ? c_i : d_i;
        max_all = (max_ab > max_cd) ? max_ab : max_cd;
        min_ab  = (a_i < b_i) ? a_i : b_i;
        min_cd  = (c_i < d_i) ? c_i : d_i;
        min_all = (min_ab < min_cd) ? min_ab : min_cd;
    end

    always_comb begin
        // Shifts and no-op codes pass the quad through unchanged.
        a_o = a_i;
        b_o = b_i;
        c_o = c_i;
        d_o = d_i;
        case (cmd_i)
            CmdMax: begin
                a_o = max_all;
                b_o = max_all;
                c_o = max_all;
                d_o = max_all;
            end
            CmdMin: begin
                a_o = min_all;
                b_o = min_all;
                c_o = min_all;
                d_o = min_all;
            end
            CmdAvg: begin
                a_o = avg;
                b_o = avg;
                c_o = avg;
                d_o = avg;
            end
            CmdRotCcw: begin
                a_o = b_i;
                b_o = d_i;
                d_o = c_i;
                c_o = a_i;
            end
            CmdRotCw: begin
                a_o = c_i;
                c_o = d_i;
                d_o = b_i;
                b_o = a_i;
            end
            CmdMirX: begin
                a_o = c_i;
                c_o = a_i;
                b_o = d_i;
                d_o = b_i;
            end
            CmdMirY: begin
                a_o = b_i;
                b_o = a_i;
                c_o = d_i;
                d_o = c_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_img_proc.sv
// LCD image processor: loads an IMG_N x IMG_N image from ROM, applies quad commands
// around a movable operation point, and streams the buffer out to RAM on request.
module lcd_img_proc
    import lcd_img_pkg::*;
#(
    parameter  int unsigned IMG_N = 8,
    parameter  int unsigned DW    = 8,
    localparam int unsigned AW    = 2 * $clog2(IMG_N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int unsigned   RW       = AW / 2;
    localparam logic [AW-1:0] LastAddr = AW'(IMG_N * IMG_N - 1);
    localparam logic [RW-1:0] MaxPt    = RW'(IMG_N - 1);
    localparam logic [RW-1:0] MinPt    = RW'(1);
    localparam logic [RW-1:0] MidPt    = RW'(IMG_N / 2);

    state_e        state_q;
    logic [AW-1:0] rom_a_q, ram_a_q, ram_a_next;
    logic [DW-1:0] ram_d_q;
    logic          rom_rd_q, ram_valid_q, done_q, busy_q;
    logic [RW-1:0] row_q, row_d, col_q, col_d;
    logic [3:0]    cmd_q;

    logic [DW-1:0] img_q [IMG_N*IMG_N];

    logic [RW-1:0] row_m1, col_m1;
    logic [AW-1:0] idx_a, idx_b, idx_c, idx_d;
    logic [DW-1:0] pix_a, pix_b, pix_c, pix_d;
    logic [DW-1:0] new_a, new_b, new_c, new_d;

    // Side is a power of two, so the linear address is just {row, col}.
    always_comb begin
        row_m1     = row_q - RW'(1);
        col_m1     = col_q - RW'(1);
        idx_a      = {row_m1, col_m1};
        idx_b      = {row_m1, col_q};
        idx_c      = {row_q, col_m1};
        idx_d      = {row_q, col_q};
        ram_a_next = ram_a_q + AW'(1);
    end

    assign pix_a = img_q[idx_a];
    assign pix_b = img_q[idx_b];
    assign pix_c = img_q[idx_c];
    assign pix_d = img_q[idx_d];

    lcd_quad_alu #(
        .DW(DW)
    ) u_alu (
        .cmd_i(cmd_q),
        .a_i  (pix_a),
        .b_i  (pix_b),
        .c_i  (pix_c),
        .d_i  (pix_d),
        .a_o  (new_a),
        .b_o  (new_b),
        .c_o  (new_c),
        .d_o  (new_d)
    );

    // Saturating point moves: a step that would leave 1..IMG_N-1 is dropped.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        case (cmd_q)
            CmdUp:    if (row_q > MinPt) row_d = row_q - RW'(1);
            CmdDown:  if (row_q < MaxPt) row_d = row_q + RW'(1);
            CmdLeft:  if (col_q > MinPt) col_d = col_q - RW'(1);
            CmdRight: if (col_q < MaxPt) col_d = col_q + RW'(1);
            default: ;
        endcase
    end

    // Image buffer is deliberately not reset; a reset only restarts the load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StLoad) begin
                img_q[rom_a_q] <= IROM_Q;
            end else if (state_q == StOp) begin
                img_q[idx_a] <= new_a;
                img_q[idx_b] <= new_b;
                img_q[idx_c] <= new_c;
                img_q[idx_d] <= new_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLoad;
            rom_a_q     <= '0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            rom_rd_q    <= 1'b1;
            ram_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            row_q       <= MidPt;
            col_q       <= MidPt;
            cmd_q       <= CmdWrite;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (rom_a_q == LastAddr) begin
                        state_q  <= StIdle;
                        rom_rd_q <= 1'b0;
                        rom_a_q  <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        rom_a_q <= rom_a_q + AW'(1);
                    end
                end
                StIdle: begin
                    if (cmd_valid && !busy_q) begin
                        cmd_q  <= cmd;
                        busy_q <= 1'b1;
                        if (cmd == CmdWrite) begin
                            state_q     <= StWrite;
                            ram_valid_q <= 1'b1;
                            ram_a_q     <= '0;
                            ram_d_q     <= img_q[0];
                        end else begin
                            state_q <= StOp;
                        end
                    end
                end
                StOp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    row_q   <= row_d;
                    col_q   <= col_d;
                end
                StWrite: begin
                    if (ram_a_q == LastAddr) begin
                        state_q     <= StDone;
                        ram_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        ram_a_q <= ram_a_next;
                        ram_d_q <= img_q[ram_a_next];
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ram_a_q <= '0;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign IROM_rd    = rom_rd_q;
    assign IROM_A     = rom_a_q;
    assign IRAM_valid = ram_valid_q;
    assign IRAM_D     = ram_d_q;
    assign IRAM_A     = ram_a_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_img_proc.sv
// Directed bench for lcd_img_proc (IMG_N=8, DW=8): ROM holds i at address i; write-outs are
// checked against a scoreboard queue filled from hand-derived expected pixel values.
module tb_lcd_img_proc;

    logic       clk;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] irom_q;
    logic       irom_rd;
    logic [5:0] irom_a;
    logic       iram_valid;
    logic [7:0] iram_d;
    logic [5:0] iram_a;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_buf [64];
    logic [13:0] exp_q [$];

    lcd_img_proc #(
        .IMG_N(8),
        .DW   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_Q    (irom_q),
        .IROM_rd   (irom_rd),
        .IROM_A    (irom_a),
        .IRAM_valid(iram_valid),
        .IRAM_D    (iram_d),
        .IRAM_A    (iram_a),
        .busy      (busy),
        .done      (done)
    );

    assign irom_q = {2'b00, irom_a};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Holds reset for two edges, checks reset outputs, then walks the 64-cycle load.
    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_rom_rd", irom_rd, 1);
        chk("rst_rom_a", irom_a, 0);
        chk("rst_ram_valid", iram_valid, 0);
        chk("rst_ram_a", iram_a, 0);
        chk("rst_ram_d", iram_d, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("load_addr", irom_a, i);
            chk("load_busy", busy, 1);
            chk("load_excl", iram_valid, 0);
            @(negedge clk);
        end
        chk("load_busy_fall", busy, 0);
        chk("load_rom_rd_fall", irom_rd, 0);
        chk("load_rom_a_zero", irom_a, 0);
        for (int i = 0; i < 64; i++) ref_buf[i] = 8'(i);
    endtask

    task automatic op(input logic [3:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("op_busy", busy, 1);
        @(negedge clk);
        chk("op_idle", busy, 0);
    endtask

    task automatic write_out();
        logic [13:0] e;
        bit fin = 0;
        for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), ref_buf[i]});
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (iram_valid) begin
                chk("wr_excl", irom_rd, 0);
                if (exp_q.size() == 0) begin
                    chk("wr_overrun", iram_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", iram_a, e[13:8]);
                    chk("wr_data", iram_d, e[7:0]);
                end
            end
            if (done) begin
                chk("done_valid", iram_valid, 0);
                chk("done_busy", busy, 1);
                chk("done_all_sent", exp_q.size(), 0);
                fin = 1;
            end
            @(negedge clk);
        end
        chk("done_seen", fin, 1);
        chk("done_pulse_once", done, 0);
        chk("post_done_busy", busy, 0);
        chk("post_done_ram_a", iram_a, 0);
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        cmd       = 4'd0;
        cmd_valid = 1'b0;

        do_reset();
        write_out();

        // Max at (4,4).
        op(4'd5);
        ref_buf[27] = 8'd36; ref_buf[28] = 8'd36; ref_buf[35] = 8'd36; ref_buf[36] = 8'd36;
        write_out();

        // Five ups saturate at row 1; average of 3,4,11,12 is 7.
        for (int i = 0; i < 5; i++) op(4'd1);
        op(4'd7);
        ref_buf[3] = 8'd7; ref_buf[4] = 8'd7; ref_buf[11] = 8'd7; ref_buf[12] = 8'd7;
        write_out();

        // Reset in the middle of a write-out.
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && iram_a != 6'd20; cyc++) @(negedge clk);
        chk("mid_wr_addr", iram_a, 20);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_wr_valid_drop", iram_valid, 0);
        chk("mid_wr_rom_restart", irom_a, 0);
        chk("mid_wr_rom_rd", irom_rd, 1);
        do_reset();

        // Rotate CCW then CW at (4,4).
        op(4'd8);
        ref_buf[27] = 8'd28; ref_buf[28] = 8'd36; ref_buf[36] = 8'd35; ref_buf[35] = 8'd27;
        write_out();
        op(4'd9);
        ref_buf[27] = 8'd27; ref_buf[28] = 8'd28; ref_buf[35] = 8'd35; ref_buf[36] = 8'd36;
        write_out();

        // Mirror X then mirror Y, then min.
        op(4'd10);
        op(4'd11);
        ref_buf[27] = 8'd36; ref_buf[28] = 8'd35; ref_buf[35] = 8'd28; ref_buf[36] = 8'd27;
        write_out();
        op(4'd6);
        ref_buf[27] = 8'd27; ref_buf[28] = 8'd27; ref_buf[35] = 8'd27; ref_buf[36] = 8'd27;

        // cmd_valid held with left: accepts only while idle, so col 4 -> 2.
        cmd       = 4'd3;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_busy", busy, (i % 2 == 0) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        op(4'd5);  // (4,2): 25,26,33,34 -> 34
        ref_buf[25] = 8'd34; ref_buf[26] = 8'd34; ref_buf[33] = 8'd34; ref_buf[34] = 8'd34;

        // Right and down past the edge saturate at 7, no-op, then average at (7,7).
        for (int i = 0; i < 6; i++) op(4'd4);
        for (int i = 0; i < 4; i++) op(4'd2);
        op(4'd12);
        op(4'd7);  // 54+55+62+63 = 234 -> 58
        ref_buf[54] = 8'd58; ref_buf[55] = 8'd58; ref_buf[62] = 8'd58; ref_buf[63] = 8'd58;
        write_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_img_proc.md
LCD_IMG_PROC -- requirements
Module: lcd_img_proc

Interface
REQ-001 SHALL have parameter IMG_N, default 8, meaning image side in pixels (power of 2, 4..64).
REQ-002 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-003 SHALL have derived localparam AW = 2*log2(IMG_N), meaning the pixel address width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd  in  4  command code.
REQ-007 SHALL have port cmd_valid  in  1  command strobe.
REQ-008 SHALL have port IROM_Q  in  DW  ROM data for the current IROM_A (combinational ROM).
REQ-009 SHALL have port IROM_rd  out  1  ROM read enable.
REQ-010 SHALL have port IROM_A  out  AW  ROM address.
REQ-011 SHALL have port IRAM_valid  out  1  RAM write strobe.
REQ-012 SHALL have port IRAM_D  out  DW  RAM write data.
REQ-013 SHALL have port IRAM_A  out  AW  RAM address.
REQ-014 SHALL have port busy  out  1  high = command not accepted.
REQ-015 SHALL have port done  out  1  one-cycle pulse ending a write-out.

Function
REQ-016 SHALL implement states LOAD, IDLE, OP, WRITE, DONE; the only path back to LOAD is reset.
REQ-017 LOAD SHALL hold IROM_rd=1 and busy=1, capture IROM_Q into buf[IROM_A] every cycle, and step IROM_A 0..IMG_N^2-1.
REQ-018 On the cycle after IROM_A=IMG_N^2-1, LOAD SHALL go to IDLE with IROM_rd=0 and IROM_A=0.
REQ-019 A command SHALL be accepted only when cmd_valid=1 and busy=0; cmd_valid while busy=1 SHALL be ignored, not queued.
REQ-020 An accepted cmd=0 SHALL enter WRITE; any other accepted cmd SHALL enter OP, with busy=1 on the next cycle.
REQ-021 OP SHALL last exactly one cycle, update the buffer and operation point at its end, and return to IDLE (busy=0 two cycles after accept).
REQ-022 The operation point SHALL be (row r, col c) with 1<=r,c<=IMG_N-1; quad a=(r-1,c-1), b=(r-1,c), c'=(r,c-1), d=(r,c).
REQ-023 Shift codes 1=up (r-1), 2=down (r+1), 3=left (c-1), 4=right (c+1) SHALL saturate: a move past 1 or IMG_N-1 SHALL leave the point unchanged.
REQ-024 Code 5 (max), 6 (min) and 7 (average) SHALL write the result to all four quad pixels; average = floor((a+b+c'+d)/4) computed at DW+2 bits.
REQ-025 Code 8 (rotate CCW) SHALL set a<=b, b<=d, d<=c', c'<=a; code 9 (rotate CW) SHALL set a<=c', c'<=d, d<=b, b<=a.
REQ-026 Code 10 (mirror X) SHALL swap a<->c' and b<->d; code 11 (mirror Y) SHALL swap a<->b and c'<->d.
REQ-027 Codes 12-15 SHALL be no-ops that still take the single OP cycle.
REQ-028 WRITE SHALL hold IRAM_valid=1 and busy=1, step IRAM_A 0..IMG_N^2-1 one per cycle, with IRAM_D=buf[IRAM_A] in the same cycle.
REQ-029 After IRAM_A=IMG_N^2-1, the FSM SHALL enter DONE for one cycle (done=1, IRAM_valid=0, busy=1), then go to IDLE with IRAM_A=0; the buffer and operation point SHALL be retained.
REQ-030 IROM_rd and IRAM_valid SHALL never be high in the same cycle.

Reset
REQ-031 While reset=1 at a clock edge: state<=LOAD, IROM_A=0, IRAM_A=0, IRAM_D=0, IROM_rd=1 next cycle, IRAM_valid=0, done=0, busy=1, point<=(IMG_N/2, IMG_N/2).
REQ-032 Reset SHALL take effect mid-LOAD, OP or WRITE, abandon the operation, and restart the load from address 0; buffer contents SHALL not be cleared.

Structure
REQ-033 A shared package lcd_img_pkg SHALL hold the command-code constants and the state enum.
REQ-034 Quad arithmetic SHALL live in one combinational sub-module lcd_quad_alu (inputs a, b, c', d and cmd; outputs four new pixels), parameterised by DW.

Verification (IMG_N=8, DW=8)
REQ-035 ROM holds buf[i]=i; reset, then check 64 load cycles -> IROM_A 0..63 and busy falls on cycle 65.
REQ-036 cmd 5 at reset point (4,4) -> pixels 27, 28, 35, 36 all become 36; cmd 0 -> IRAM_D at addresses 27, 28, 35, 36 equals 36, and done pulses once after address 63.
REQ-037 cmd 1 issued 5 times from (4,4) -> point (1,4); cmd 7 -> pixels 3, 4, 11, 12 become 7 (floor of 30/4).
REQ-038 cmd 8 at (4,4) -> buf[27]=28, buf[28]=36, buf[36]=35, buf[35]=27; cmd 9 restores the original values.
REQ-039 cmd_valid held high with cmd=3 through busy -> exactly one left shift per accept; right shift at c=7 -> point unchanged.
REQ-040 reset asserted at IRAM_A=20 -> IRAM_valid=0 next cycle and IROM_A restarts at 0.
